regread_stage: RTL and testbench

- Operand-read stage that feeds the execute units and receives their results back.
- Accepts a decoded instruction and reads rs1/rs2 from a 32-entry register file.
- Tracks outstanding destination registers with a scoreboard and stalls decode on RAW hazards.
- Presents registered operands and pass-through decode fields to execute with read_valid; execute results return on the writeback port and update the register file.

---
 rtl/regread_stage.sv | 131 +++++++++++++
 tb/tb_regread_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regread_stage.sv
// Operand read stage: scoreboarded RAW stall, 1-cycle accept-to-read_valid, no execute back-pressure.
// Define REGREAD_WB_BYPASS_EN to forward same-cycle writebacks to decode and release their hazard early.
module regread_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              decode_valid,
  output logic              decode_ready,
  input  logic [AW-1:0]     decode_rs1,
  input  logic [AW-1:0]     decode_rs2,
  input  logic [AW-1:0]     decode_rd,
  input  logic              decode_uses_rs1,
  input  logic              decode_uses_rs2,
  input  logic              decode_writes_rd,
  input  logic [6:0]        decode_opcode,
  input  logic [2:0]        decode_funct3,
  input  logic [6:0]        decode_funct7,
  input  logic [31:0]       decode_imm,
  input  logic [31:0]       decode_pc,
  output logic              read_valid,
  output logic [DATA_W-1:0] read_rs1_val,
  output logic [DATA_W-1:0] read_rs2_val,
  output logic [AW-1:0]     read_rd,
  output logic [6:0]        read_opcode,
  output logic [2:0]        read_funct3,
  output logic [6:0]        read_funct7,
  output logic [31:0]       read_imm,
  output logic [31:0]       read_pc,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_val
);

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc;
  } pass_t;

  logic [DATA_W-1:0]    rf [REG_COUNT];
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pend_eff;
  logic [REG_COUNT-1:0] wb_hit;
  logic [REG_COUNT-1:0] set_mask;
  logic                 hazard;
  logic                 accept;
  logic [DATA_W-1:0]    rs1_val;
  logic [DATA_W-1:0]    rs2_val;
  pass_t                pass_d;
  pass_t                pass_q;

  always_comb begin
    wb_hit = '0;
    if (wb_valid) wb_hit[wb_rd] = 1'b1;
  end

`ifdef REGREAD_WB_BYPASS_EN
  assign pend_eff = pending & ~wb_hit;
`else
  assign pend_eff = pending;
`endif

  assign hazard       = (decode_uses_rs1 & pend_eff[decode_rs1]) |
                        (decode_uses_rs2 & pend_eff[decode_rs2]);
  assign decode_ready = ~hazard & ~flush;
  assign accept       = decode_valid & decode_ready;

  always_comb begin
    set_mask = '0;
    if (accept && decode_writes_rd) set_mask[decode_rd] = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_comb begin
    rs1_val = (decode_rs1 == '0) ? '0 : rf[decode_rs1];
    rs2_val = (decode_rs2 == '0) ? '0 : rf[decode_rs2];
`ifdef REGREAD_WB_BYPASS_EN
    if (wb_valid && wb_rd != '0 && wb_rd == decode_rs1) rs1_val = wb_val;
    if (wb_valid && wb_rd != '0 && wb_rd == decode_rs2) rs2_val = wb_val;
`endif
  end

  assign pass_d = '{opcode: decode_opcode, funct3: decode_funct3, funct7: decode_funct7,
                    imm: decode_imm, pc: decode_pc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      rf[wb_rd] <= wb_val;
    end
  end

  // Set is applied after clear so a new producer keeps ownership on a same-edge collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= (pending & ~wb_hit) | set_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid   <= 1'b0;
      read_rs1_val <= '0;
      read_rs2_val <= '0;
      read_rd      <= '0;
      pass_q       <= '0;
    end else begin
      read_valid <= accept;
      if (accept) begin
        read_rs1_val <= rs1_val;
        read_rs2_val <= rs2_val;
        read_rd      <= decode_rd;
        pass_q       <= pass_d;
      end
    end
  end

  assign read_opcode = pass_q.opcode;
  assign read_funct3 = pass_q.funct3;
  assign read_funct7 = pass_q.funct7;
  assign read_imm    = pass_q.imm;
  assign read_pc     = pass_q.pc;

endmodule

// File: tb/tb_regread_stage.sv
// Directed table, corner sequences and randomized run against an array-based model of regread_stage.
module tb_regread_stage;

`ifdef REGREAD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        decode_valid = 1'b0;
  logic        decode_ready;
  logic [4:0]  decode_rs1 = '0, decode_rs2 = '0, decode_rd = '0;
  logic        decode_uses_rs1 = 1'b0, decode_uses_rs2 = 1'b0, decode_writes_rd = 1'b0;
  logic [6:0]  decode_opcode = '0;
  logic [2:0]  decode_funct3 = '0;
  logic [6:0]  decode_funct7 = '0;
  logic [31:0] decode_imm = '0, decode_pc = '0;
  logic        read_valid;
  logic [31:0] read_rs1_val, read_rs2_val;
  logic [4:0]  read_rd;
  logic [6:0]  read_opcode;
  logic [2:0]  read_funct3;
  logic [6:0]  read_funct7;
  logic [31:0] read_imm, read_pc;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_val = '0;

  int checks = 0;
  int failures = 0;

  regread_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
    .decode_uses_rs1(decode_uses_rs1), .decode_uses_rs2(decode_uses_rs2),
    .decode_writes_rd(decode_writes_rd),
    .decode_opcode(decode_opcode), .decode_funct3(decode_funct3), .decode_funct7(decode_funct7),
    .decode_imm(decode_imm), .decode_pc(decode_pc),
    .read_valid(read_valid), .read_rs1_val(read_rs1_val), .read_rs2_val(read_rs2_val),
    .read_rd(read_rd), .read_opcode(read_opcode), .read_funct3(read_funct3),
    .read_funct7(read_funct7), .read_imm(read_imm), .read_pc(read_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, dv, u1, u2, wr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbval;
    logic        e_rdy, e_rv;
    logic [31:0] e_r1, e_r2;
  } vec_t;

  vec_t tbl [12];

  // Reference state: architectural registers, outstanding producers, last presented outputs.
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  logic        m_vld;
  logic [31:0] m_r1, m_r2, m_imm, m_pc;
  logic [4:0]  m_rd;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; decode_valid = 0; decode_uses_rs1 = 0; decode_uses_rs2 = 0;
    decode_writes_rd = 0; decode_rs1 = 0; decode_rs2 = 0; decode_rd = 0;
    decode_opcode = 0; decode_funct3 = 0; decode_funct7 = 0; decode_imm = 0; decode_pc = 0;
    wb_valid = 0; wb_rd = 0; wb_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_pend[r] = 0; end
    m_vld = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
  endtask

  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !(BYP && wb_valid && wb_rd == r);
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (BYP && wb_valid && wb_rd == r) return wb_val;
    return m_rf[r];
  endfunction

  initial begin
    logic        e_rdy, acc;
    logic [31:0] op1, op2;
    int          pq[$];

    tbl[0]  = '{0,0,0,0,0, 0,0,0, 32'h0,   1,5,32'h1234,     1,0, 32'h0,    32'h0};
    tbl[1]  = '{0,1,1,1,0, 5,0,0, 32'h100, 0,0,32'h0,        1,1, 32'h1234, 32'h0};
    tbl[2]  = '{0,0,0,0,0, 0,0,0, 32'h0,   1,0,32'hFFFFFFFF, 1,0, 32'h0,    32'h0};
    tbl[3]  = '{0,1,1,1,1, 0,0,0, 32'h104, 0,0,32'h0,        1,1, 32'h0,    32'h0};
    tbl[4]  = '{0,1,1,1,0, 0,5,0, 32'h108, 0,0,32'h0,        1,1, 32'h0,    32'h1234};
    tbl[5]  = '{0,1,0,0,1, 0,0,7, 32'h10C, 1,7,32'h77,       1,1, 32'h0,    32'h0};
    tbl[6]  = '{0,1,1,0,0, 7,0,0, 32'h110, 0,0,32'h0,        0,0, 32'h0,    32'h0};
    tbl[7]  = '{0,0,0,0,0, 0,0,0, 32'h0,   1,7,32'h99,       1,0, 32'h0,    32'h0};
    tbl[8]  = '{0,1,1,0,0, 7,0,0, 32'h114, 0,0,32'h0,        1,1, 32'h99,   32'h0};
    tbl[9]  = '{0,1,0,0,1, 0,0,4, 32'h118, 0,0,32'h0,        1,1, 32'h0,    32'h0};
    tbl[10] = '{1,1,1,0,0, 4,0,0, 32'h11C, 0,0,32'h0,        0,0, 32'h0,    32'h0};
    tbl[11] = '{0,1,1,0,0, 4,0,0, 32'h120, 0,0,32'h0,        1,1, 32'h0,    32'h0};

    #1;
    chk("reset_read_valid", {31'b0, read_valid}, 32'h0);
    chk("reset_read_pc", read_pc, 32'h0);
    chk("reset_rs1_val", read_rs1_val, 32'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      flush = tbl[i].fl; decode_valid = tbl[i].dv;
      decode_uses_rs1 = tbl[i].u1; decode_uses_rs2 = tbl[i].u2; decode_writes_rd = tbl[i].wr;
      decode_rs1 = tbl[i].rs1; decode_rs2 = tbl[i].rs2; decode_rd = tbl[i].rd;
      decode_pc = tbl[i].pc; decode_imm = ~tbl[i].pc;
      wb_valid = tbl[i].wbv; wb_rd = tbl[i].wbrd; wb_val = tbl[i].wbval;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'b0, decode_ready}, {31'b0, tbl[i].e_rdy});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_read_valid", i), {31'b0, read_valid}, {31'b0, tbl[i].e_rv});
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_rs1", i), read_rs1_val, tbl[i].e_r1);
        chk($sformatf("tbl%0d_rs2", i), read_rs2_val, tbl[i].e_r2);
        chk($sformatf("tbl%0d_pc", i), read_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_rd", i), {27'b0, read_rd}, {27'b0, tbl[i].rd});
      end
      @(negedge clk);
    end

    // RAW stall on x3 released by its writeback.
    do_reset();
    decode_valid = 1; decode_rd = 3; decode_writes_rd = 1;
    #1 chk("raw_producer_ready", {31'b0, decode_ready}, 32'h1);
    @(negedge clk);
    decode_writes_rd = 0; decode_rd = 0; decode_uses_rs1 = 1; decode_rs1 = 3;
    #1 chk("raw_stall_ready", {31'b0, decode_ready}, 32'h0);
    @(posedge clk); #1 chk("raw_stall_valid", {31'b0, read_valid}, 32'h0);
    @(negedge clk);
    wb_valid = 1; wb_rd = 3; wb_val = 32'hCAFE;
    #1;
`ifdef REGREAD_WB_BYPASS_EN
    chk("raw_bypass_ready", {31'b0, decode_ready}, 32'h1);
    @(posedge clk); #1;
    chk("raw_bypass_valid", {31'b0, read_valid}, 32'h1);
    chk("raw_bypass_rs1", read_rs1_val, 32'hCAFE);
    @(negedge clk);
`else
    chk("raw_wb_cycle_ready", {31'b0, decode_ready}, 32'h0);
    @(posedge clk); #1 chk("raw_wb_cycle_valid", {31'b0, read_valid}, 32'h0);
    @(negedge clk);
    wb_valid = 0;
    #1 chk("raw_after_wb_ready", {31'b0, decode_ready}, 32'h1);
    @(posedge clk); #1;
    chk("raw_after_wb_valid", {31'b0, read_valid}, 32'h1);
    chk("raw_after_wb_rs1", read_rs1_val, 32'hCAFE);
    @(negedge clk);
`endif

    // Back-to-back accepts, then reset asserted while read_valid is high.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      decode_valid = 1; decode_pc = 32'h200 + 32'(4 * i); decode_imm = 32'(17 * (i + 1));
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_valid", i), {31'b0, read_valid}, 32'h1);
      chk($sformatf("b2b%0d_pc", i), read_pc, 32'h200 + 32'(4 * i));
      chk($sformatf("b2b%0d_imm", i), read_imm, 32'(17 * (i + 1)));
      if (i < 3) @(negedge clk);
    end
    #2 reset = 0;
    #1;
    chk("async_reset_valid", {31'b0, read_valid}, 32'h0);
    chk("async_reset_pc", read_pc, 32'h0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      flush = ($urandom_range(0, 31) == 0);
      decode_valid = ($urandom_range(0, 3) != 0);
      decode_rs1 = 5'($urandom_range(0, 7)); decode_rs2 = 5'($urandom_range(0, 7));
      decode_rd = 5'($urandom_range(0, 7));
      decode_uses_rs1 = 1'($urandom); decode_uses_rs2 = 1'($urandom); decode_writes_rd = 1'($urandom);
      decode_opcode = 7'($urandom); decode_funct3 = 3'($urandom); decode_funct7 = 7'($urandom);
      decode_imm = $urandom; decode_pc = $urandom;
      wb_valid = ($urandom_range(0, 2) == 0);
      pq.delete();
      for (int r = 0; r < 32; r++) if (m_pend[r]) pq.push_back(r);
      if (pq.size() > 0 && $urandom_range(0, 1) == 1) wb_rd = 5'(pq[$urandom_range(0, pq.size() - 1)]);
      else wb_rd = 5'($urandom_range(0, 7));
      wb_val = $urandom;
      #1;
      e_rdy = !flush && !((decode_uses_rs1 && busy(decode_rs1)) || (decode_uses_rs2 && busy(decode_rs2)));
      chk("rnd_ready", {31'b0, decode_ready}, {31'b0, e_rdy});
      acc = decode_valid && e_rdy;
      op1 = opval(decode_rs1); op2 = opval(decode_rs2);
      if (wb_valid && wb_rd != 0) m_rf[wb_rd] = wb_val;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
      end else begin
        if (wb_valid) m_pend[wb_rd] = 0;
        if (acc && decode_writes_rd && decode_rd != 0) m_pend[decode_rd] = 1;
      end
      m_vld = acc;
      if (acc) begin
        m_r1 = op1; m_r2 = op2; m_rd = decode_rd; m_pc = decode_pc; m_imm = decode_imm;
        m_op = decode_opcode; m_f3 = decode_funct3; m_f7 = decode_funct7;
      end
      @(posedge clk); #1;
      chk("rnd_read_valid", {31'b0, read_valid}, {31'b0, m_vld});
      chk("rnd_rs1", read_rs1_val, m_r1);
      chk("rnd_rs2", read_rs2_val, m_r2);
      chk("rnd_rd", {27'b0, read_rd}, {27'b0, m_rd});
      chk("rnd_pc", read_pc, m_pc);
      chk("rnd_imm", read_imm, m_imm);
      chk("rnd_fields", {15'b0, read_opcode, read_funct3, read_funct7}, {15'b0, m_op, m_f3, m_f7});
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
